dram_arbiter: RTL

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter_pkg.sv | 10 +
 rtl/dram_arbiter_tag.sv | 51 +++++
 rtl/dram_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared constants for the two-requester DRAM arbiter: widths, requester IDs and count.
package dram_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 18;
  localparam int NUM_REQ    = 2;
  localparam int REQ_CONV   = 0;
  localparam int REQ_POOL   = 1;

endpackage

// File: rtl/dram_arbiter_tag.sv
// Synchronous FIFO of 1-bit requester IDs, one entry per outstanding DRAM read.
module tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when an entry leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port between the conv and pool layers,
// with a tag FIFO that routes in-order read returns back to their requester.
module dram_arbiter #(
  parameter int DATA_WIDTH = dram_arbiter_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = dram_arbiter_pkg::ADDR_WIDTH,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic [1:0]              req_rd,
  input  logic [1:0]              req_wr,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              gnt,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    dram_en_wr,
  output logic [ADDR_WIDTH-1:0]   dram_addr_wr,
  output logic [DATA_WIDTH-1:0]   dram_data_wr,
  output logic                    dram_en_rd,
  output logic [ADDR_WIDTH-1:0]   dram_addr_rd,
  input  logic                    dram_valid,
  input  logic [DATA_WIDTH-1:0]   dram_data_rd,
  output logic                    err_orphan
);

  import dram_arbiter_pkg::*;

  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;
  logic                  gnt_any;
  logic                  gnt_sel;
  logic                  gnt_is_wr;
  logic                  tag_free;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_dout;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  last_q;
  logic                  en_wr_q;
  logic                  en_rd_q;
  logic [ADDR_WIDTH-1:0] addr_wr_q;
  logic [ADDR_WIDTH-1:0] addr_rd_q;
  logic [DATA_WIDTH-1:0] data_wr_q;
  logic                  err_orphan_q;
  logic                  err_orphan_d;

  assign fifo_pop = dram_valid && !fifo_empty && !srst;
  // A read may only be granted if its tag has somewhere to go this cycle.
  assign tag_free = (fifo_count < CNT_W'(TAG_DEPTH)) || (fifo_full && fifo_pop);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign elig[gi]      = req_wr[gi] || (req_rd[gi] && tag_free);
    assign gnt[gi]       = gnt_any && (gnt_sel == 1'(gi));
    assign rsp_valid[gi] = fifo_pop && (fifo_dout == 1'(gi));
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = 1'(REQ_CONV);
    if (!srst) begin
      if (&elig) begin
        gnt_any = 1'b1;
        gnt_sel = ~last_q;
      end else if (elig[REQ_CONV]) begin
        gnt_any = 1'b1;
        gnt_sel = 1'(REQ_CONV);
      end else if (elig[REQ_POOL]) begin
        gnt_any = 1'b1;
        gnt_sel = 1'(REQ_POOL);
      end
    end
  end

  // A requester holding both read and write is served its write first.
  assign gnt_is_wr    = req_wr[gnt_sel];
  assign fifo_push    = gnt_any && !gnt_is_wr;
  assign err_orphan_d = err_orphan_q || (dram_valid && fifo_empty);

  tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .srst  (srst),
    .push  (fifo_push),
    .din   (gnt_sel),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      last_q       <= 1'(REQ_POOL);
      en_wr_q      <= 1'b0;
      en_rd_q      <= 1'b0;
      addr_wr_q    <= '0;
      addr_rd_q    <= '0;
      data_wr_q    <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      en_wr_q      <= gnt_any && gnt_is_wr;
      en_rd_q      <= fifo_push;
      err_orphan_q <= err_orphan_d;
      if (gnt_any) begin
        last_q <= gnt_sel;
      end
      if (gnt_any && gnt_is_wr) begin
        addr_wr_q <= addr_arr[gnt_sel];
        data_wr_q <= wdata_arr[gnt_sel];
      end
      if (fifo_push) begin
        addr_rd_q <= addr_arr[gnt_sel];
      end
    end
  end

  assign dram_en_wr   = en_wr_q;
  assign dram_addr_wr = addr_wr_q;
  assign dram_data_wr = data_wr_q;
  assign dram_en_rd   = en_rd_q;
  assign dram_addr_rd = addr_rd_q;
  assign rsp_data     = dram_data_rd;
  assign err_orphan   = err_orphan_q;

endmodule
